alu_add_seq: RTL
================

// Module: alu_add_seq
// PURPOSE
//  Parametrised multi-cycle adder/subtractor for the ECPU ALU. It is the
//  successor to the fixed 16-bit ripple adder, generalised to WIDTH bits.
//  It processes CHUNK bits per clock through a small ripple slice. It adds
//  carry-in, a subtract mode, and the carry/signed-overflow/zero flags.
//  Operands enter and results leave on valid/ready handshakes, sitting
//  between the operand latch and the ALU result mux.
// PARAMETERS
//  WIDTH  16  operand/result width in bits; must be >= 2
//  CHUNK  4   bits added per cycle; WIDTH % CHUNK == 0 (elaboration error otherwise)
// PORTS
//  clk           in   1      single clock, all state on rising edge
//  reset_n       in   1      synchronous reset, active low
//  in_valid      in   1      operands a/b/cin/sub valid
//  in_ready      out  1      block can accept operands
//  a             in   WIDTH  operand A (unsigned or two's complement)
//  b             in   WIDTH  operand B
//  cin           in   1      carry-in (add) / borrow-in (sub)
//  sub           in   1      0: a+b+cin   1: a-b-cin
//  out_valid     out  1      result and flags valid
//  out_ready     in   1      consumer takes result
//  out           out  WIDTH  result, modulo 2^WIDTH
//  carry         out  1      add: carry out of MSB; sub: borrow (1 = a < b+cin unsigned)
//  overflow      out  1      signed overflow = carry into MSB XOR carry out of MSB
//  zero          out  1      out == 0
// BEHAVIOUR
//  - Clock/reset: one clock. Reset is synchronous, active-low (reset_n sampled on clk rise).
//  - Reset values: state=IDLE, in_ready=1, out_valid=0, out/carry/overflow/zero=0.
//  - NCHUNK = WIDTH/CHUNK. FSM states: IDLE, RUN, DONE.
//  - IDLE: in_ready=1, out_valid=0.
//    - On in_valid&&in_ready, latch a.
//    - Latch b^{WIDTH{sub}} as b_eff.
//    - Latch carry register = cin^sub (sub: a+~b+~cin).
//    - Latch the sub flag, set idx=0, go RUN.
//  - RUN: in_ready=0. Each cycle:
//    - Add chunk idx of a and b_eff plus the carry register.
//    - Write the sum into result bits [idx*CHUNK +: CHUNK].
//    - Update the carry register from the slice carry-out.
//    - On idx==NCHUNK-1, capture the slice carry-into-MSB for overflow and go DONE.
//    - Otherwise idx++.
//  - DONE: out_valid=1. Flags computed from the final carry:
//    - carry = cout^sub.
//    - overflow = c_msb_in^cout.
//    - zero = ~|out.
//    - out and flags hold stable while out_valid&&!out_ready.
//    - On out_ready, go IDLE next cycle.
//  - Latency: handshake at edge k -> out_valid high after edge k+NCHUNK+1.
//    NCHUNK RUN cycles, then DONE. No operand overlap: in_ready is 0 in RUN and DONE.
//  - out/flags are don't-care-stable outside DONE. They keep the last result and are not cleared.
//  - in_valid while busy is ignored. The producer must hold operands until in_ready.
//  - out_ready while out_valid=0 has no effect.
//  - Reset mid-RUN or in DONE: next edge returns to IDLE with reset values.
//    The partial result is discarded and no out_valid pulse occurs.
//  - CHUNK==WIDTH is legal: single RUN cycle.
// STRUCTURE
//  - Shared constants go in defines/ECPU_def.v: FSM state encodings
//    (`ALU_SEQ_IDLE/RUN/DONE, 2 bits) and the flag bit indices for the flag bus.
//  - Sub-module alu_add_chunk #(CHUNK): combinational ripple of FullAdder cells.
//    Ports: a, b, cin, sum, cout, c_msb_in.
//  - Top holds the FSM, idx counter ($clog2(NCHUNK), min 1 bit), operand/result
//    registers and flag logic.
// TESTING
//  1. W=16,C=4: a=0x1234,b=0x1111,cin=0,sub=0 -> out=0x2345,carry=0,ovf=0,zero=0;
//     out_valid exactly 5 cycles after accept.
//  2. a=0xFFFF,b=0x0001,sub=0 -> out=0x0000,carry=1,ovf=0,zero=1.
//     a=0x7FFF,b=0x0001 -> out=0x8000,carry=0,ovf=1.
//  3. sub=1: a=0x0005,b=0x0007,cin=0 -> out=0xFFFE,carry(borrow)=1,ovf=0.
//     a=0x8000,b=0x0001 -> out=0x7FFF,ovf=1,carry=0.
//  4. Backpressure: hold out_ready=0 for 10 cycles -> out/flags/out_valid stable.
//     in_valid pulses during busy are ignored. out_ready=1 -> in_ready=1 next cycle.
//  5. Reset: drive reset_n=0 in cycle 2 of RUN -> next edge out_valid=0,
//     in_ready=1, flags 0. New op a=3,b=4 -> out=7.
//  6. Params W=32,C=8 and W=8,C=8: random 1000 ops vs a+b+cin / a-b-cin
//     reference model, incl. cin=1 cases; latency = NCHUNK+1.

Source files
------------

// File: rtl/alu_add_seq_pkg.sv
// Shared types for the sequential ALU adder/subtractor.
// Contents:
//   alu_seq_state_e : FSM state encoding (IDLE/RUN/DONE, 2 bits)
//   alu_flags_t     : packed flag bus {zero, overflow, carry}
//   make_flags      : derives the flag bus from the final adder carries
package alu_add_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } alu_seq_state_e;

    typedef struct packed {
        logic zero;
        logic overflow;
        logic carry;
    } alu_flags_t;

    // Subtract runs as a + ~b + ~bin, so the MSB carry-out is an inverted borrow.
    function automatic alu_flags_t make_flags(
        input logic cout,
        input logic c_msb_in,
        input logic sub,
        input logic is_zero
    );
        alu_flags_t f;
        f.carry    = cout ^ sub;
        f.overflow = c_msb_in ^ cout;
        f.zero     = is_zero;
        return f;
    endfunction

endpackage

// File: rtl/alu_add_seq_chunk.sv
// Combinational CHUNK-bit ripple slice built from full-adder cells.
// Ports:
//   a, b     : slice operands
//   cin      : carry into bit 0
//   sum      : slice sum
//   cout     : carry out of the top bit
//   c_msb_in : carry into the top bit (used for signed overflow)
module alu_add_seq_chunk #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    // One full-adder cell per bit.
    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign sum[i]  = a[i] ^ b[i] ^ c[i];
        assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout     = c[CHUNK];
    assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/alu_add_seq.sv
// Multi-cycle WIDTH-bit adder/subtractor processing CHUNK bits per clock.
// Ports:
//   clk, reset_n         : clock, synchronous active-low reset
//   in_valid / in_ready  : operand handshake (a, b, cin, sub)
//   a, b                 : WIDTH-bit operands
//   cin                  : carry-in (add) / borrow-in (sub)
//   sub                  : 0 = a+b+cin, 1 = a-b-cin
//   out_valid / out_ready: result handshake
//   out                  : WIDTH-bit result
//   carry, overflow, zero: result flags (carry is borrow when subtracting)
module alu_add_seq
    import alu_add_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0]  IDX_LAST   = IDXW'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

    if (WIDTH < 2 || (WIDTH % CHUNK) != 0) begin : g_param_check
        $error("alu_add_seq: WIDTH must be >= 2 and a multiple of CHUNK");
    end

    alu_seq_state_e   state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             cry_q, cry_d;
    logic             sub_q, sub_d;
    logic             cmsb_q, cmsb_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_q, out_d;
    alu_flags_t       flags_q, flags_d;

    int unsigned      shamt;
    logic [CHUNK-1:0] slice_sum;
    logic             slice_cout;
    logic             slice_cmsb;

    // Bit offset of the chunk being processed this cycle.
    assign shamt = 32'(idx_q) * CHUNK;

    alu_add_seq_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a        (CHUNK'(a_q >> shamt)),
        .b        (CHUNK'(b_q >> shamt)),
        .cin      (cry_q),
        .sum      (slice_sum),
        .cout     (slice_cout),
        .c_msb_in (slice_cmsb)
    );

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        cry_d       = cry_q;
        sub_d       = sub_q;
        cmsb_d      = cmsb_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        flags_d     = flags_q;

        unique case (state_q)
            ST_IDLE: begin
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                if (in_valid && in_ready_q) begin
                    // Subtract is folded into an add of ~b with inverted borrow-in.
                    a_d        = a;
                    b_d        = b ^ {WIDTH{sub}};
                    cry_d      = cin ^ sub;
                    sub_d      = sub;
                    idx_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                res_d = (res_q & ~(CHUNK_MASK << shamt)) | (WIDTH'(slice_sum) << shamt);
                cry_d = slice_cout;
                if (idx_q == IDX_LAST) begin
                    cmsb_d  = slice_cmsb;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            ST_DONE: begin
                // First DONE cycle publishes the result; it then holds until taken.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    out_d       = res_q;
                    flags_d     = make_flags(cry_q, cmsb_q, sub_q, ~|res_q);
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            cry_q       <= 1'b0;
            sub_q       <= 1'b0;
            cmsb_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            cry_q       <= cry_d;
            sub_q       <= sub_d;
            cmsb_q      <= cmsb_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            flags_q     <= flags_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign carry     = flags_q.carry;
    assign overflow  = flags_q.overflow;
    assign zero      = flags_q.zero;

endmodule
